// File: rtl/pwl_sweep_engine.sv
// Time-multiplexed period/amplitude sweep engine: one slot per cycle over 2*CHANNELS slots per tick.
// Latency: slot k updates at the k+1-th edge after the tick; rd_data is registered (1 cycle); no backpressure, ticks while busy set overrun.
module pwl_sweep_engine #(
    parameter int CHANNELS    = 4,
    parameter int PERIOD_BITS = 13,
    parameter int AMP_BITS    = 6,
    parameter int STEP_BITS   = 5,
    parameter int INT_BITS    = 8,
    localparam int SW         = 3 + STEP_BITS + INT_BITS,
    localparam int A          = $clog2(CHANNELS) + 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tick,
    input  logic                            wr_en,
    input  logic [A-1:0]                    wr_addr,
    input  logic [15:0]                     wr_data,
    input  logic [A-1:0]                    rd_addr,
    output logic [15:0]                     rd_data,
    input  logic                            clr_overrun,
    output logic [CHANNELS*PERIOD_BITS-1:0] periods,
    output logic [CHANNELS*AMP_BITS-1:0]    amps,
    output logic                            busy,
    output logic                            overrun
);

    localparam int CHW = $clog2(CHANNELS);
    localparam int SLW = CHW + 1;
    localparam int PCW = ((PERIOD_BITS > STEP_BITS) ? PERIOD_BITS : STEP_BITS) + 1;
    localparam int ACW = ((AMP_BITS > STEP_BITS) ? AMP_BITS : STEP_BITS) + 1;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;

    localparam logic [PERIOD_BITS-1:0] PMAX = {PERIOD_BITS{1'b1}};
    localparam logic [AMP_BITS-1:0]    AMAX = {AMP_BITS{1'b1}};

    logic [0:0]             state_q, state_d;
    logic [SLW-1:0]         slot_q, slot_d;
    logic [PERIOD_BITS-1:0] period_q [CHANNELS];
    logic [PERIOD_BITS-1:0] period_d [CHANNELS];
    logic [AMP_BITS-1:0]    amp_q [CHANNELS];
    logic [AMP_BITS-1:0]    amp_d [CHANNELS];
    logic [SW-1:0]          psw_q [CHANNELS];
    logic [SW-1:0]          psw_d [CHANNELS];
    logic [SW-1:0]          asw_q [CHANNELS];
    logic [SW-1:0]          asw_d [CHANNELS];
    logic [INT_BITS-1:0]    cnt_q [2*CHANNELS];
    logic [INT_BITS-1:0]    cnt_d [2*CHANNELS];
    logic                   overrun_q, overrun_d;
    logic [15:0]            rd_data_q, rd_data_d;

    // Current slot decode
    logic [CHW-1:0]       s_ch;
    logic                 s_amp;
    logic [SW-1:0]        s_sw;
    logic                 s_en, s_dir, s_wrap;
    logic [STEP_BITS-1:0] s_step;
    logic [INT_BITS-1:0]  s_int;
    logic [INT_BITS-1:0]  s_cnt;
    logic                 s_run;

    logic [PCW-1:0]         p_ext, p_stp, p_sum;
    logic [PERIOD_BITS-1:0] p_dif, p_new;
    logic                   p_clip;
    logic [ACW-1:0]         a_ext, a_stp, a_sum;
    logic [AMP_BITS-1:0]    a_dif, a_new;
    logic                   a_clip;
    logic                   s_sat;

    logic [CHW-1:0] w_ch;
    logic [1:0]     w_fld;
    logic           val_wr_hit;
    logic [CHW-1:0] r_ch;

    always_comb begin
        s_ch   = slot_q[SLW-1:1];
        s_amp  = slot_q[0];
        s_sw   = s_amp ? asw_q[s_ch] : psw_q[s_ch];
        s_en   = s_sw[SW-1];
        s_dir  = s_sw[SW-2];
        s_wrap = s_sw[SW-3];
        s_step = s_sw[INT_BITS +: STEP_BITS];
        s_int  = s_sw[INT_BITS-1:0];
        s_cnt  = cnt_q[slot_q];
        s_run  = (state_q == STATE_RUN);
    end

    // Step arithmetic is computed in a widened domain so range checks never alias
    always_comb begin
        p_ext  = PCW'(period_q[s_ch]);
        p_stp  = PCW'(s_step);
        p_sum  = p_ext + p_stp;
        p_dif  = period_q[s_ch] - PERIOD_BITS'(s_step);
        p_clip = s_dir ? (p_stp > p_ext) : (p_sum > PCW'(PMAX));
        if (!s_wrap && p_clip) begin
            p_new = s_dir ? '0 : PMAX;
        end else begin
            p_new = s_dir ? p_dif : p_sum[PERIOD_BITS-1:0];
        end

        a_ext  = ACW'(amp_q[s_ch]);
        a_stp  = ACW'(s_step);
        a_sum  = a_ext + a_stp;
        a_dif  = amp_q[s_ch] - AMP_BITS'(s_step);
        a_clip = s_dir ? (a_stp > a_ext) : (a_sum > ACW'(AMAX));
        if (!s_wrap && a_clip) begin
            a_new = s_dir ? '0 : AMAX;
        end else begin
            a_new = s_dir ? a_dif : a_sum[AMP_BITS-1:0];
        end

        s_sat = !s_wrap && (s_amp ? a_clip : p_clip);
    end

    always_comb begin
        w_ch       = wr_addr[A-1:2];
        w_fld      = wr_addr[1:0];
        val_wr_hit = wr_en && (w_ch == s_ch) && (w_fld == {1'b0, s_amp});

        period_d = period_q;
        amp_d    = amp_q;
        psw_d    = psw_q;
        asw_d    = asw_q;
        cnt_d    = cnt_q;

        if (s_run) begin
            if (!s_en) begin
                cnt_d[slot_q] = '0;
            end else if (s_cnt == s_int) begin
                cnt_d[slot_q] = '0;
                // A colliding register write owns the value and suppresses the en clear
                if (!val_wr_hit) begin
                    if (s_amp) begin
                        amp_d[s_ch] = a_new;
                        if (s_sat) asw_d[s_ch][SW-1] = 1'b0;
                    end else begin
                        period_d[s_ch] = p_new;
                        if (s_sat) psw_d[s_ch][SW-1] = 1'b0;
                    end
                end
            end else begin
                cnt_d[slot_q] = s_cnt + INT_BITS'(1);
            end
        end

        if (wr_en) begin
            case (w_fld)
                2'd0:    period_d[w_ch] = PERIOD_BITS'(wr_data);
                2'd1:    amp_d[w_ch]    = AMP_BITS'(wr_data);
                2'd2:    psw_d[w_ch]    = SW'(wr_data);
                default: asw_d[w_ch]    = SW'(wr_data);
            endcase
            if (w_fld[1]) cnt_d[{w_ch, w_fld[0]}] = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            STATE_IDLE: begin
                if (tick) begin
                    state_d = STATE_RUN;
                    slot_d  = '0;
                end
            end
            default: begin
                if (&slot_q) begin
                    state_d = STATE_IDLE;
                    slot_d  = '0;
                end else begin
                    slot_d = slot_q + SLW'(1);
                end
            end
        endcase

        overrun_d = overrun_q;
        if (clr_overrun) overrun_d = 1'b0;
        if (tick && s_run) overrun_d = 1'b1;
    end

    always_comb begin
        r_ch = rd_addr[A-1:2];
        case (rd_addr[1:0])
            2'd0:    rd_data_d = 16'(period_q[r_ch]);
            2'd1:    rd_data_d = 16'(amp_q[r_ch]);
            2'd2:    rd_data_d = 16'(psw_q[r_ch]);
            default: rd_data_d = 16'(asw_q[r_ch]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= STATE_IDLE;
            slot_q    <= '0;
            overrun_q <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                period_q[i] <= '0;
                amp_q[i]    <= '0;
                psw_q[i]    <= '0;
                asw_q[i]    <= '0;
            end
            for (int i = 0; i < 2*CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            overrun_q <= overrun_d;
            rd_data_q <= rd_data_d;
            period_q  <= period_d;
            amp_q     <= amp_d;
            psw_q     <= psw_d;
            asw_q     <= asw_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            periods[c*PERIOD_BITS +: PERIOD_BITS] = period_q[c];
            amps[c*AMP_BITS +: AMP_BITS]          = amp_q[c];
        end
    end

    assign busy    = (state_q == STATE_RUN);
    assign overrun = overrun_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_pwl_sweep_engine.sv
// Directed bench for pwl_sweep_engine: default 4-channel instance plus an 8-channel/16-bit-period instance.
module tb_pwl_sweep_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        clr_overrun = 1'b0;
    logic [51:0] periods;
    logic [23:0] amps;
    logic        busy;
    logic        overrun;

    logic         tick8 = 1'b0;
    logic         wr_en8 = 1'b0;
    logic [4:0]   wr_addr8 = '0;
    logic [15:0]  wr_data8 = '0;
    logic [4:0]   rd_addr8 = '0;
    logic [15:0]  rd_data8;
    logic [127:0] periods8;
    logic [47:0]  amps8;
    logic         busy8;
    logic         overrun8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwl_sweep_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .clr_overrun(clr_overrun),
        .periods(periods), .amps(amps), .busy(busy), .overrun(overrun)
    );

    pwl_sweep_engine #(.CHANNELS(8), .PERIOD_BITS(16)) dut8 (
        .clk(clk), .reset(reset), .tick(tick8), .wr_en(wr_en8), .wr_addr(wr_addr8),
        .wr_data(wr_data8), .rd_addr(rd_addr8), .rd_data(rd_data8), .clr_overrun(1'b0),
        .periods(periods8), .amps(amps8), .busy(busy8), .overrun(overrun8)
    );

    function automatic logic [15:0] sw(input logic en, input logic dir, input logic wrap,
                                       input logic [4:0] step, input logic [7:0] ival);
        return {en, dir, wrap, step, ival};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic wr8(input logic [4:0] a, input logic [15:0] d);
        wr_en8 = 1'b1; wr_addr8 = a; wr_data8 = d;
        cyc();
        wr_en8 = 1'b0;
    endtask

    task automatic pass();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (8) cyc();
    endtask

    initial begin
        cyc();
        // Build nonzero state including a pending overrun, then reset mid-pass
        wr(4'd0, 16'd123);
        wr(4'd1, 16'd5);
        wr(4'd2, sw(1, 0, 0, 1, 0));
        tick = 1'b1;
        cyc();
        cyc();
        tick = 1'b0;
        chk("pre_reset_overrun", overrun, 1);
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_periods", periods, 0);
        chk("rst_amps", amps, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy8", busy8, 0);

        // Up sweep with saturation on ch1 period
        wr(4'd4, 16'd8180);
        wr(4'd6, sw(1, 0, 0, 5, 0));
        pass();
        chk("sat_pass1", periods[25:13], 8185);
        pass();
        chk("sat_pass2", periods[25:13], 8190);
        pass();
        chk("sat_pass3", periods[25:13], 8191);
        rd_addr = 4'd6;
        cyc();
        chk("sat_en_cleared", rd_data, sw(0, 0, 0, 5, 0));
        pass();
        chk("sat_pass4", periods[25:13], 8191);
        rd_addr = 4'd4;
        cyc();
        chk("rd_ch1_period", rd_data, 8191);

        // Down sweep with wrap on ch2 amp, stepping every second tick
        wr(4'd9, 16'd3);
        wr(4'd11, sw(1, 1, 1, 4, 1));
        pass();
        chk("wrap_tick1", amps[17:12], 3);
        pass();
        chk("wrap_tick2", amps[17:12], 63);
        pass();
        chk("wrap_tick3", amps[17:12], 63);
        pass();
        chk("wrap_tick4", amps[17:12], 59);

        // Pass timing and overrun
        wr(4'd2, sw(1, 0, 0, 1, 0));
        wr(4'd15, sw(1, 0, 0, 1, 0));
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("t0_busy", busy, 1);
        chk("t0_p0", periods[12:0], 0);
        cyc();
        chk("t1_p0", periods[12:0], 1);
        repeat (3) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("t5_overrun", overrun, 1);
        chk("t5_busy", busy, 1);
        cyc();
        cyc();
        chk("t7_busy", busy, 1);
        chk("t7_a3", amps[23:18], 0);
        cyc();
        chk("t8_a3", amps[23:18], 1);
        chk("t8_busy", busy, 0);
        cyc();
        chk("no_extra_pass_busy", busy, 0);
        chk("no_extra_pass_p0", periods[12:0], 1);
        clr_overrun = 1'b1;
        cyc();
        clr_overrun = 1'b0;
        chk("clr_overrun", overrun, 0);

        // Tick on the final slot edge still counts as overrun
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (7) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("last_slot_overrun", overrun, 1);
        chk("last_slot_busy", busy, 0);
        cyc();
        chk("last_slot_ignored", busy, 0);
        clr_overrun = 1'b1;
        cyc();
        clr_overrun = 1'b0;

        // Register write colliding with the engine update of ch0 amp
        wr(4'd3, sw(1, 0, 0, 1, 0));
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        wr(4'd1, 16'd20);
        chk("collide_write_wins", amps[5:0], 20);
        repeat (6) cyc();
        chk("collide_after_pass", amps[5:0], 20);
        pass();
        chk("collide_next_pass", amps[5:0], 21);

        // Eight-channel instance with 16-bit periods
        wr8(5'd28, 16'd65530);
        wr8(5'd30, sw(1, 0, 1, 10, 0));
        wr8(5'd29, 16'd60);
        wr8(5'd31, sw(1, 0, 0, 7, 0));
        wr8(5'd20, 16'd1000);
        wr8(5'd22, sw(1, 1, 0, 3, 0));
        tick8 = 1'b1;
        cyc();
        tick8 = 1'b0;
        repeat (14) cyc();
        chk("p8_t14_busy", busy8, 1);
        chk("p8_t14_p7", periods8[127:112], 65530);
        cyc();
        chk("p8_t15_p7", periods8[127:112], 4);
        chk("p8_t15_a7", amps8[47:42], 60);
        cyc();
        chk("p8_t16_a7", amps8[47:42], 63);
        chk("p8_t16_busy", busy8, 0);
        chk("p8_p5", periods8[95:80], 997);
        rd_addr8 = 5'd31;
        cyc();
        chk("p8_a7_en_cleared", rd_data8, sw(0, 0, 0, 7, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
